cfntt_addr_gen: RTL and testbench
=================================

// Module: cfntt_addr_gen
// PURPOSE
//  Address generator for 1024-point in-place radix-2 NTT/INTT; direct upstream of conflict_free_memory_map.
//  Each beat issues two butterflies of one stage as four 10-bit addresses (old_address_0..3).
//  The four addresses differ only in the two bits of one base-4 digit, so the sum-of-digits bank map puts them in 4 distinct banks.
//  Sequences all stages, inserts a pipeline-drain gap between stages and pulses done.
// PARAMETERS
//  ADDR_W      10  coefficient address width (N=1024); fixed by the downstream mapper
//  STAGES      10  number of butterfly stages (log2 N)
//  GAP_CYCLES  6   idle cycles between stages (covers memory/butterfly RAW latency); 0 allowed
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  start          in   1   one-cycle start request; accepted only in IDLE
//  inverse        in   1   0: NTT, stages 9->0; 1: INTT, stages 0->9; sampled with start
//  stall          in   1   1: hold the current beat (downstream back-pressure)
//  busy           out  1   state != IDLE
//  done           out  1   one-cycle pulse after the last beat of the last stage
//  addr_valid     out  1   old_address_* hold a new beat this cycle
//  stage          out  4   stage of the beat currently on the outputs
//  old_address_0  out  10  butterfly A, low input
//  old_address_1  out  10  butterfly A, high input
//  old_address_2  out  10  butterfly B, low input
//  old_address_3  out  10  butterfly B, high input
//  tw_index_0     out  9   twiddle exponent, butterfly A (CFNTT_TWIDDLE_ADDR_EN only)
//  tw_index_1     out  9   twiddle exponent, butterfly B (CFNTT_TWIDDLE_ADDR_EN only)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; internal beat counter c[7:0]=0; stage counter=0; gap counter=0.
//  - FSM IDLE -> RUN -> (GAP -> RUN)* -> DONE -> IDLE.
//    IDLE: on start, latch inverse; stage = inverse?0:9; c=0; enter RUN.
//    RUN: each cycle with stall=0, load the output registers with beat c and set addr_valid=1; c++.
//         Stall=1: c holds, outputs hold, addr_valid=0.
//    End of RUN (beat c=255 issued): last stage -> DONE; else advance stage (+/-1) and go to GAP.
//         If GAP_CYCLES=0, go straight back to RUN.
//    GAP: count GAP_CYCLES cycles (stall ignored), then RUN with c=0. DONE: done=1 for one cycle, then IDLE.
//  - Latency: start sampled at edge k; first addr_valid after edge k+1 when stall=0.
//    Unstalled total: 10*256 beats + 9*GAP_CYCLES.
//  - Address arithmetic for stage s, digit d=s>>1, partner bit t=s^1, h=2^s, g=2^t:
//    base = {c[7:2d], 2'b00, c[2d-1:0]} (zeros at bits 2d+1:2d).
//    addr0 = base, addr1 = base|h, addr2 = base|g, addr3 = base|h|g. All values are unsigned and never wrap.
//  - start while busy is ignored. rst mid-operation aborts to IDLE and clears all outputs on the same edge.
//  - addr_valid=0 in IDLE, GAP and DONE; outputs keep their last values there.
// CONFIGURATION
//  - CFNTT_TWIDDLE_ADDR_EN defined: tw_index_0 = (addr0 mod 2^s) << (9-s); tw_index_1 = (addr2 mod 2^s) << (9-s).
//    Both are registered alongside the addresses.
//  - Not defined: tw_index_* ports are absent and no twiddle logic is built.
// STRUCTURE
//  - Package cfntt_pkg holds N=1024, LOGN=10, LANES=4, the BANK_W/BANK_ADDR_W constants and the state enum (IDLE, RUN, GAP, DONE).
//  - One sub-module, cfntt_digit_insert: combinational (c, d) -> base, zero-insertion at digit d.
//  - All outputs are registered. Downstream conflict_free_memory_map adds 1 more cycle.
// TESTING
//  - Stage 0, c=0: addrs 0,1,2,3. Stage 1, c=0: addrs 0,2,1,3.
//  - Stage 4, c=5: addrs 5,21,37,53; with twiddle enabled, tw_index_0=160 and tw_index_1=160.
//  - Stage 5, c=5: addrs 5,37,21,53; with twiddle enabled, tw_index_0=80 and tw_index_1=336.
//  - Stage 9, c=255: addrs 255,767,511,1023.
//  - Full run, inverse=0, GAP_CYCLES=6, no stall: 2560 valid beats and stages 9..0 in order.
//    done pulses once, 2614 cycles after the first valid beat.
//  - Every beat yields 4 distinct (sum of 2-bit digits mod 4) banks.
//  - Mid-run: stall high for 3 cycles at beat 100 gives 3 addr_valid=0 cycles and no skipped or repeated beat.
//  - rst at beat 300: next cycle busy=0, outputs 0.
//  - start during busy: ignored.

Source files
------------

// File: rtl/cfntt_pkg.sv
// Shared constants and FSM state type for the conflict-free NTT address generator.
package cfntt_pkg;

    localparam int N           = 1024;
    localparam int LOGN        = 10;
    localparam int LANES       = 4;
    localparam int BANK_W      = 2;
    localparam int BANK_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/cfntt_digit_insert.sv
// Inserts a zero base-4 digit at position d into the beat counter, yielding the
// butterfly-pair base address for the current stage.
module cfntt_digit_insert
    import cfntt_pkg::*;
#(
    parameter int ADDR_W = LOGN
) (
    input  logic [BANK_ADDR_W-1:0] c,
    input  logic [2:0]             d,
    output logic [ADDR_W-1:0]      base
);

    logic [ADDR_W-1:0] c_ext;
    logic [ADDR_W-1:0] lo_mask;
    logic [3:0]        shamt;

    always_comb begin
        c_ext   = ADDR_W'(c);
        shamt   = 4'(d) * 4'(BANK_W);
        lo_mask = (ADDR_W'(1) << shamt) - ADDR_W'(1);
        // Bits at and above the digit move up one digit; bits below stay put.
        base    = ((c_ext >> shamt) << (shamt + 4'(BANK_W))) | (c_ext & lo_mask);
    end

endmodule

// File: rtl/cfntt_addr_gen.sv
// Address generator for a 1024-point in-place radix-2 NTT/INTT: two butterflies per beat.
// Optional twiddle exponent outputs are built when CFNTT_TWIDDLE_ADDR_EN is defined.
module cfntt_addr_gen
    import cfntt_pkg::*;
#(
    parameter int ADDR_W     = $clog2(N),
    parameter int STAGES     = LOGN,
    parameter int GAP_CYCLES = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inverse,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              addr_valid,
    output logic [3:0]        stage,
    output logic [ADDR_W-1:0] old_address_0,
    output logic [ADDR_W-1:0] old_address_1,
    output logic [ADDR_W-1:0] old_address_2,
`ifdef CFNTT_TWIDDLE_ADDR_EN
    output logic [ADDR_W-1:0] old_address_3,
    output logic [8:0]        tw_index_0,
    output logic [8:0]        tw_index_1
`else
    output logic [ADDR_W-1:0] old_address_3
`endif
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [3:0] TOP_STAGE = 4'(STAGES - 1);
    localparam logic [BANK_ADDR_W-1:0] LAST_BEAT = '1;

    state_t                 state_reg, state_next;
    logic [BANK_ADDR_W-1:0] beat_reg, beat_next;
    logic [3:0]             stage_reg, stage_next;
    logic [GAP_W-1:0]       gap_reg, gap_next;
    logic                   inverse_reg, inverse_next;
    logic                   load;
    logic                   done_next;
    logic                   is_last;

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] h_bit;
    logic [ADDR_W-1:0] g_bit;
    logic [ADDR_W-1:0] lane_addr [LANES];

    cfntt_digit_insert #(.ADDR_W(ADDR_W)) u_digit_insert (
        .c    (beat_reg),
        .d    (stage_reg[3:1]),
        .base (base)
    );

    assign h_bit = ADDR_W'(1) << stage_reg;
    assign g_bit = ADDR_W'(1) << (stage_reg ^ 4'd1);

    // Lane bit 0 selects the stage bit, lane bit 1 the partner bit of the same digit.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_addr[gi] = base
                                 | (((gi % 2) == 1) ? h_bit : '0)
                                 | (((gi / 2) == 1) ? g_bit : '0);
        end
    endgenerate

    assign busy    = (state_reg != IDLE);
    assign is_last = inverse_reg ? (stage_reg == TOP_STAGE) : (stage_reg == 4'd0);

    always_comb begin
        state_next   = state_reg;
        beat_next    = beat_reg;
        stage_next   = stage_reg;
        gap_next     = gap_reg;
        inverse_next = inverse_reg;
        load         = 1'b0;
        done_next    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    inverse_next = inverse;
                    stage_next   = inverse ? 4'd0 : TOP_STAGE;
                    beat_next    = '0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    load      = 1'b1;
                    beat_next = beat_reg + BANK_ADDR_W'(1);
                    if (beat_reg == LAST_BEAT) begin
                        if (is_last) begin
                            state_next = DONE;
                        end else begin
                            stage_next = inverse_reg ? stage_reg + 4'd1 : stage_reg - 4'd1;
                            gap_next   = '0;
                            state_next = (GAP_CYCLES == 0) ? RUN : GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_reg == GAP_W'(GAP_CYCLES - 1)) begin
                    beat_next  = '0;
                    state_next = RUN;
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            beat_reg      <= '0;
            stage_reg     <= '0;
            gap_reg       <= '0;
            inverse_reg   <= 1'b0;
            addr_valid    <= 1'b0;
            done          <= 1'b0;
            stage         <= '0;
            old_address_0 <= '0;
            old_address_1 <= '0;
            old_address_2 <= '0;
            old_address_3 <= '0;
        end else begin
            state_reg   <= state_next;
            beat_reg    <= beat_next;
            stage_reg   <= stage_next;
            gap_reg     <= gap_next;
            inverse_reg <= inverse_next;
            addr_valid  <= load;
            done        <= done_next;
            if (load) begin
                stage         <= stage_reg;
                old_address_0 <= lane_addr[0];
                old_address_1 <= lane_addr[1];
                old_address_2 <= lane_addr[2];
                old_address_3 <= lane_addr[3];
            end
        end
    end

`ifdef CFNTT_TWIDDLE_ADDR_EN
    logic [ADDR_W-1:0] tw_mask;
    logic [3:0]        tw_shift;

    // Exponent is the low s bits of the low input, left-aligned to 9 bits.
    assign tw_mask  = h_bit - ADDR_W'(1);
    assign tw_shift = TOP_STAGE - stage_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tw_index_0 <= '0;
            tw_index_1 <= '0;
        end else if (load) begin
            tw_index_0 <= 9'(lane_addr[0] & tw_mask) << tw_shift;
            tw_index_1 <= 9'(lane_addr[2] & tw_mask) << tw_shift;
        end
    end
`endif

endmodule

// File: tb/tb_cfntt_addr_gen.sv
// Scoreboard bench for cfntt_addr_gen: arithmetic reference model, random stall/start noise,
// directed stall, abort-by-reset and done-latency checks.
module tb_cfntt_addr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       inverse;
    logic       stall;
    logic       busy;
    logic       done;
    logic       addr_valid;
    logic [3:0] stage;
    logic [9:0] old_address_0, old_address_1, old_address_2, old_address_3;
`ifdef CFNTT_TWIDDLE_ADDR_EN
    logic [8:0] tw_index_0, tw_index_1;
`endif

    cfntt_addr_gen dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .inverse       (inverse),
        .stall         (stall),
        .busy          (busy),
        .done          (done),
        .addr_valid    (addr_valid),
        .stage         (stage),
        .old_address_0 (old_address_0),
        .old_address_1 (old_address_1),
        .old_address_2 (old_address_2),
`ifdef CFNTT_TWIDDLE_ADDR_EN
        .old_address_3 (old_address_3),
        .tw_index_0    (tw_index_0),
        .tw_index_1    (tw_index_1)
`else
        .old_address_3 (old_address_3)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int c;
        int a0;
        int a1;
        int a2;
        int a3;
        int tw0;
        int tw1;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks      = 0;
    int   failures    = 0;
    int   cyc         = 0;
    int   run_beats   = 0;
    int   done_count  = 0;
    int   first_cyc   = 0;
    int   done_cyc    = 0;
    int   run_id      = 0;

    // Directed vectors: stage, beat, four addresses, two twiddle exponents.
    int vec_s   [5] = '{0, 1, 4, 5, 9};
    int vec_c   [5] = '{0, 0, 5, 5, 255};
    int vec_a   [5][4] = '{'{0, 1, 2, 3}, '{0, 2, 1, 3}, '{5, 21, 37, 53},
                           '{5, 37, 21, 53}, '{255, 767, 511, 1023}};
    int vec_tw  [5][2] = '{'{0, 0}, '{0, 256}, '{160, 160}, '{80, 336}, '{255, 511}};

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint pack4(input int x0, input int x1, input int x2, input int x3);
        return (longint'(x0) << 30) | (longint'(x1) << 20) | (longint'(x2) << 10) | longint'(x3);
    endfunction

    function automatic int bank_of(input int a);
        int sum = 0;
        for (int i = 0; i < 5; i++) sum += (a >> (2 * i)) % 4;
        return sum % 4;
    endfunction

    // Reference: pairs of a stage enumerated by inserting a zero base-4 digit into c.
    function automatic void push_run(input bit inv);
        exp_t e;
        int   s, p, base, h, g;
        for (int k = 0; k < 10; k++) begin
            s = inv ? k : 9 - k;
            p = 1 << (2 * (s / 2));
            h = 1 << s;
            g = 1 << (s ^ 1);
            for (int c = 0; c < 256; c++) begin
                base  = (c / p) * p * 4 + (c % p);
                e.s   = s;
                e.c   = c;
                e.a0  = base;
                e.a1  = base + h;
                e.a2  = base + g;
                e.a3  = base + h + g;
                e.tw0 = (base % h) * (512 / h);
                e.tw1 = ((base + g) % h) * (512 / h);
                exp_q.push_back(e);
            end
        end
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (addr_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_stage", stage, mon_e.s);
                chk("beat_addrs", pack4(old_address_0, old_address_1, old_address_2, old_address_3),
                    pack4(mon_e.a0, mon_e.a1, mon_e.a2, mon_e.a3));
                chk("bank_distinct", (4'b1 << bank_of(old_address_0)) | (4'b1 << bank_of(old_address_1))
                    | (4'b1 << bank_of(old_address_2)) | (4'b1 << bank_of(old_address_3)), 15);
`ifdef CFNTT_TWIDDLE_ADDR_EN
                chk("beat_tw", pack4(0, 0, tw_index_0, tw_index_1), pack4(0, 0, mon_e.tw0, mon_e.tw1));
`endif
                for (int v = 0; v < 5; v++) begin
                    if (mon_e.s == vec_s[v] && mon_e.c == vec_c[v]) begin
                        chk("vector_addrs", pack4(old_address_0, old_address_1, old_address_2, old_address_3),
                            pack4(vec_a[v][0], vec_a[v][1], vec_a[v][2], vec_a[v][3]));
`ifdef CFNTT_TWIDDLE_ADDR_EN
                        chk("vector_tw", pack4(0, 0, tw_index_0, tw_index_1),
                            pack4(0, 0, vec_tw[v][0], vec_tw[v][1]));
`endif
                    end
                end
                $display("beat run=%0d stage=%0d c=%0d addr=%0d,%0d,%0d,%0d", run_id, stage, mon_e.c,
                         old_address_0, old_address_1, old_address_2, old_address_3);
            end
            if (run_beats == 0) first_cyc = cyc;
            run_beats++;
        end
    end

    // mode 0: clean run; mode 1: directed + random stalls, ignored starts; mode 2: reset at beat 300.
    task automatic run(input bit inv, input int mode);
        bit finished   = 1'b0;
        bit did_stall  = 1'b0;
        int stall_left = 0;
        int guard      = 0;
        run_id++;
        run_beats  = 0;
        done_count = 0;
        push_run(inv);
        @(posedge clk); #1;
        start   = 1'b1;
        inverse = inv;
        @(posedge clk); #1;
        start   = 1'b0;
        inverse = ~inv;
        chk("busy_after_start", busy, 1);
        chk("valid_after_start", addr_valid, 0);
        @(posedge clk); #1;
        chk("first_beat_valid", addr_valid, 1);
        while (!finished && guard < 6000) begin
            guard++;
            if (mode == 1) begin
                if (stall_left > 0) begin
                    chk("stall_gap_valid", addr_valid, 0);
                    stall_left--;
                    if (stall_left == 0) stall = 1'b0;
                end else if (!did_stall && addr_valid && run_beats == 100) begin
                    stall      = 1'b1;
                    stall_left = 3;
                    did_stall  = 1'b1;
                end else begin
                    stall   = (run_beats > 200) && ($urandom_range(0, 7) == 0);
                    start   = (run_beats < 2000) && ($urandom_range(0, 31) == 0);
                    inverse = 1'($urandom_range(0, 1));
                end
            end
            if (mode == 2 && addr_valid && run_beats == 300) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("abort_busy", busy, 0);
                chk("abort_valid", addr_valid, 0);
                chk("abort_stage", stage, 0);
                chk("abort_addrs", pack4(old_address_0, old_address_1, old_address_2, old_address_3), 0);
                rst = 1'b0;
                exp_q.delete();
                finished = 1'b1;
            end else if (done_count > 0) begin
                finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk); #1;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        if (!finished) chk("run_timeout", 0, 1);
        if (mode != 2) begin
            repeat (4) @(posedge clk);
            #1;
            chk("done_pulse_count", done_count, 1);
            chk("idle_after_done", busy, 0);
            chk("queue_drained", exp_q.size(), 0);
            chk("beats_issued", run_beats, 2560);
            if (mode == 0) chk("done_latency", done_cyc - first_cyc, 2614);
        end
        $display("run %0d inverse=%0d mode=%0d beats=%0d done_pulses=%0d", run_id, inv, mode,
                 run_beats, done_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        inverse = 1'b0;
        stall   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_valid", addr_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_stage", stage, 0);
        chk("reset_addrs", pack4(old_address_0, old_address_1, old_address_2, old_address_3), 0);
        rst = 1'b0;
        run(1'b0, 0);
        run(1'b1, 1);
        run(1'b0, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_abort", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
